// File: rtl/washer_setting_ctrl.sv
// Program / water-level selector with click auto-repeat and a RUN/PAUSE countdown.
// data = {water, stage mask (W,R,S), remaining}; done pulses once when the countdown hits zero.
module washer_setting_ctrl #(
    parameter int N_PROG     = 6,
    parameter int PROG_W     = 3,
    parameter int N_WATER    = 5,
    parameter int DEF_WATER  = 2,
    parameter int WASH_T     = 10,
    parameter int RINSE_T    = 6,
    parameter int SPIN_T     = 5,
    parameter int TIME_W     = 20,
    parameter int TICK_DIV   = 4,
    parameter int REPEAT_EN  = 1,
    parameter int REPEAT_DLY = 8,
    parameter int REPEAT_PER = 4
) (
    input  logic              cp,
    input  logic              rst,
    input  logic              click,
    input  logic              waterBtn,
    input  logic [2:0]        state,
    output logic [PROG_W-1:0] setData,
    output logic [TIME_W+5:0] data,
    output logic              done
);

    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [63:0] TSAT = (64'd1 << TIME_W) - 64'd1;

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_IDLE  = 3'd1,
        S_SET   = 3'd2,
        S_RUN   = 3'd3,
        S_PAUSE = 3'd4
    } st_t;

    st_t               st, prev_st;
    logic [PROG_W-1:0] prog, prog_nxt;
    logic [2:0]        water, water_nxt;
    logic [TIME_W-1:0] remaining, rem_nxt, total;
    logic [TW-1:0]     tick_cnt, tick_nxt;
    logic [RW-1:0]     rep_cnt, rep_nxt;
    logic              click_q;
    logic              press, fire, edit, done_nxt;
    logic [2:0]        mask;
    logic [63:0]       sum;
    logic [TIME_W+5:0] data_nxt;

    always_comb begin
        case (state)
            3'd1:    st = S_IDLE;
            3'd2:    st = S_SET;
            3'd3:    st = S_RUN;
            3'd4:    st = S_PAUSE;
            default: st = S_OFF;
        endcase
    end

    // Stage mask and total run time for the currently selected program/level
    always_comb begin
        case (32'(prog) % 32'd6)
            0:       mask = 3'b111;
            1:       mask = 3'b100;
            2:       mask = 3'b110;
            3:       mask = 3'b011;
            4:       mask = 3'b010;
            default: mask = 3'b001;
        endcase
        sum = 64'd0;
        if (mask[2]) sum = sum + 64'(WASH_T) * 64'(water);
        if (mask[1]) sum = sum + 64'(RINSE_T) * 64'(water);
        if (mask[0]) sum = sum + 64'(SPIN_T);
        total = (sum > TSAT) ? TSAT[TIME_W-1:0] : sum[TIME_W-1:0];
    end

    // rep_cnt counts down to the next auto-repeat while the button stays held
    always_comb begin
        press   = click & ~click_q;
        fire    = (REPEAT_EN != 0) && click && click_q && (rep_cnt == '0);
        edit    = press | fire;
        rep_nxt = '0;
        if (press)
            rep_nxt = RW'(REPEAT_DLY - 1);
        else if (click && click_q)
            rep_nxt = (rep_cnt == '0) ? RW'(REPEAT_PER - 1) : rep_cnt - RW'(1);
    end

    always_comb begin
        prog_nxt  = prog;
        water_nxt = water;
        rem_nxt   = remaining;
        tick_nxt  = tick_cnt;
        done_nxt  = 1'b0;
        case (st)
            S_OFF: begin
                prog_nxt  = '0;
                water_nxt = 3'(DEF_WATER);
                rem_nxt   = '0;
                tick_nxt  = '0;
            end
            S_IDLE: begin
                rem_nxt  = total;
                tick_nxt = '0;
            end
            S_SET: begin
                rem_nxt  = total;
                tick_nxt = '0;
                if (edit) begin
                    if (waterBtn)
                        water_nxt = (water == 3'(N_WATER)) ? 3'd1 : water + 3'd1;
                    else
                        prog_nxt = (prog == PROG_W'(N_PROG - 1)) ? '0 : prog + PROG_W'(1);
                end
            end
            S_RUN: begin
                if (prev_st != S_RUN && prev_st != S_PAUSE) begin
                    rem_nxt  = total;
                    tick_nxt = '0;
                end else if (tick_cnt == TW'(TICK_DIV - 1)) begin
                    tick_nxt = '0;
                    if (remaining != '0) begin
                        rem_nxt  = remaining - TIME_W'(1);
                        done_nxt = (remaining == TIME_W'(1));
                    end
                end else begin
                    tick_nxt = tick_cnt + TW'(1);
                end
            end
            default: ; // PAUSE freezes the countdown
        endcase
        data_nxt = (st == S_OFF) ? '0 : {water, mask, rem_nxt};
    end

    always_ff @(posedge cp) begin
        if (rst) begin
            prog      <= '0;
            water     <= 3'(DEF_WATER);
            remaining <= '0;
            tick_cnt  <= '0;
            click_q   <= 1'b0;
            rep_cnt   <= '0;
            prev_st   <= S_OFF;
            done      <= 1'b0;
            data      <= '0;
        end else begin
            prog      <= prog_nxt;
            water     <= water_nxt;
            remaining <= rem_nxt;
            tick_cnt  <= tick_nxt;
            click_q   <= click;
            rep_cnt   <= rep_nxt;
            prev_st   <= st;
            done      <= done_nxt;
            data      <= data_nxt;
        end
    end

    assign setData = prog;

endmodule

// File: tb/tb_washer_setting_ctrl.sv
// Randomized + directed bench for washer_setting_ctrl against a spec-level model.
module tb_washer_setting_ctrl;

    localparam int N_PROG = 6, PROG_W = 3, N_WATER = 5, DEF_WATER = 2;
    localparam int WASH_T = 10, RINSE_T = 6, SPIN_T = 5, TIME_W = 20;
    localparam int TICK_DIV = 4, REPEAT_EN = 1, REPEAT_DLY = 8, REPEAT_PER = 4;

    logic              cp = 1'b0;
    logic              rst = 1'b1;
    logic              click = 1'b0;
    logic              waterBtn = 1'b0;
    logic [2:0]        state = 3'd2;
    logic [PROG_W-1:0] setData;
    logic [TIME_W+5:0] data;
    logic              done;

    int npass = 0, ntotal = 0;
    int mp = 0, mw = DEF_WATER, mheld = 0;
    logic [TIME_W+5:0] exp_d;

    washer_setting_ctrl #(
        .N_PROG(N_PROG), .PROG_W(PROG_W), .N_WATER(N_WATER), .DEF_WATER(DEF_WATER),
        .WASH_T(WASH_T), .RINSE_T(RINSE_T), .SPIN_T(SPIN_T), .TIME_W(TIME_W),
        .TICK_DIV(TICK_DIV), .REPEAT_EN(REPEAT_EN), .REPEAT_DLY(REPEAT_DLY),
        .REPEAT_PER(REPEAT_PER)
    ) dut (
        .cp(cp), .rst(rst), .click(click), .waterBtn(waterBtn), .state(state),
        .setData(setData), .data(data), .done(done)
    );

    always #5 cp = ~cp;

    function automatic logic [2:0] mmask(int p);
        logic [2:0] tbl [6] = '{3'b111, 3'b100, 3'b110, 3'b011, 3'b010, 3'b001};
        return tbl[p % 6];
    endfunction

    function automatic int mtotal(int p, int w);
        logic [2:0] m = mmask(p);
        longint s = 0;
        if (m[2]) s += WASH_T * w;
        if (m[1]) s += RINSE_T * w;
        if (m[0]) s += SPIN_T;
        if (s > (64'd1 << TIME_W) - 1) s = (64'd1 << TIME_W) - 1;
        return int'(s);
    endfunction

    function automatic logic [TIME_W+5:0] mdata(int p, int w);
        return {3'(w), mmask(p), TIME_W'(mtotal(p, w))};
    endfunction

    // One clock with the given inputs; model updated from the user-visible rules
    task automatic drive_cycle(input logic c, input logic wb, input logic [2:0] st);
        int pp = mp, pw = mw;
        bit ed;
        click = c; waterBtn = wb; state = st;
        @(posedge cp);
        ed = c && (mheld == 0 ||
             (REPEAT_EN != 0 && mheld >= REPEAT_DLY && (mheld - REPEAT_DLY) % REPEAT_PER == 0));
        if (st == 3'd0 || st > 3'd4) begin
            mp = 0; mw = DEF_WATER;
        end else if (st == 3'd2 && ed) begin
            if (wb) mw = (mw == N_WATER) ? 1 : mw + 1;
            else    mp = (mp == N_PROG - 1) ? 0 : mp + 1;
        end
        mheld = c ? mheld + 1 : 0;
        exp_d = (st == 3'd0 || st > 3'd4) ? '0 : mdata(pp, pw);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; state = 3'd2;
        repeat (2) @(posedge cp);
        #1;
        ntotal++;
        if (data !== '0 || done !== 1'b0 || setData !== '0) begin
            $display("FAIL reset_hold data=%h done=%b setData=%0d required 0/0/0", data, done, setData);
        end else npass++;
        rst = 1'b0;
        drive_cycle(1'b0, 1'b0, 3'd2);
        ntotal++;
        if (setData !== 3'd0 || data !== {3'd2, 3'b111, 20'd37} || done !== 1'b0)
            $display("FAIL reset_release setData=%0d data=%h done=%b required 0/%h/0",
                     setData, data, done, {3'd2, 3'b111, 20'd37});
        else npass++;
    endtask

    task automatic test_prog_edit();
        repeat (2) begin
            drive_cycle(1'b1, 1'b0, 3'd2);
            drive_cycle(1'b0, 1'b0, 3'd2);
        end
        ntotal++;
        if (setData !== 3'd2 || data !== {3'd2, 3'b110, 20'd32})
            $display("FAIL prog_edit setData=%0d data=%h required 2/%h", setData, data,
                     {3'd2, 3'b110, 20'd32});
        else npass++;
    endtask

    task automatic test_water_edit();
        repeat (4) begin
            drive_cycle(1'b1, 1'b1, 3'd2);
            drive_cycle(1'b0, 1'b1, 3'd2);
            ntotal++;
            if (data !== exp_d) $display("FAIL water_step data=%h required %h", data, exp_d);
            else npass++;
        end
        ntotal++;
        if (data !== {3'd1, 3'b110, 20'd16})
            $display("FAIL water_wrap data=%h required %h", data, {3'd1, 3'b110, 20'd16});
        else npass++;
    endtask

    task automatic test_ignored();
        logic [2:0] sts [2] = '{3'd1, 3'd4};
        foreach (sts[k]) begin
            repeat (3) begin
                drive_cycle(1'b1, k[0], sts[k]);
                drive_cycle(1'b0, k[0], sts[k]);
            end
            ntotal++;
            if (setData !== 3'd2 || data[25:23] !== 3'd1)
                $display("FAIL ignore_state%0d setData=%0d water=%0d required 2/1",
                         sts[k], setData, data[25:23]);
            else npass++;
        end
        repeat (2) drive_cycle(1'b1, 1'b0, 3'd3);
        drive_cycle(1'b0, 1'b0, 3'd3);
        ntotal++;
        if (setData !== 3'd2 || data[25:23] !== 3'd1)
            $display("FAIL ignore_run setData=%0d water=%0d required 2/1", setData, data[25:23]);
        else npass++;
        drive_cycle(1'b1, 1'b0, 3'd0);
        drive_cycle(1'b0, 1'b0, 3'd0);
        ntotal++;
        if (setData !== 3'd0 || data !== '0 || done !== 1'b0)
            $display("FAIL off_state setData=%0d data=%h done=%b required 0/0/0", setData, data, done);
        else npass++;
        drive_cycle(1'b0, 1'b0, 3'd2);
        repeat (6) begin
            drive_cycle(1'b1, 1'b0, 3'd2);
            drive_cycle(1'b0, 1'b0, 3'd2);
            ntotal++;
            if (setData !== PROG_W'(mp) || data !== exp_d)
                $display("FAIL prog_cycle setData=%0d data=%h required %0d/%h", setData, data, mp, exp_d);
            else npass++;
        end
        ntotal++;
        if (setData !== 3'd0 || data[25:23] !== 3'(DEF_WATER))
            $display("FAIL prog_wrap setData=%0d water=%0d required 0/%0d", setData, data[25:23], DEF_WATER);
        else npass++;
    endtask

    task automatic test_repeat();
        repeat (4) begin
            drive_cycle(1'b1, 1'b0, 3'd2);
            drive_cycle(1'b0, 1'b0, 3'd2);
        end
        for (int i = 0; i < 17; i++) begin
            drive_cycle(1'b1, 1'b0, 3'd2);
            ntotal++;
            if (setData !== PROG_W'(mp))
                $display("FAIL repeat_cyc%0d setData=%0d required %0d", i, setData, mp);
            else npass++;
        end
        drive_cycle(1'b0, 1'b0, 3'd2);
        ntotal++;
        if (setData !== 3'd2) $display("FAIL repeat_final setData=%0d required 2", setData);
        else npass++;
    endtask

    task automatic test_random();
        logic c = 1'b0, wb = 1'b0;
        logic [2:0] st;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) c = ~c;
            if ($urandom_range(0, 4) == 0) wb = ~wb;
            case ($urandom_range(0, 39))
                0:       st = 3'd0;
                1:       st = 3'd7;
                2, 3, 4: st = 3'd1;
                default: st = 3'd2;
            endcase
            drive_cycle(c, wb, st);
            ntotal++;
            if (setData !== PROG_W'(mp) || data !== exp_d || done !== 1'b0)
                $display("FAIL random_cyc%0d setData=%0d data=%h done=%b required %0d/%h/0",
                         i, setData, data, done, mp, exp_d);
            else npass++;
        end
        drive_cycle(1'b0, 1'b0, 3'd2);
    endtask

    // Run a countdown; pause for pause_len edges starting at edge pause_at (0 = none)
    task automatic run_countdown(input int pause_at, input int pause_len, input int tot);
        int seen = 0, frozen = 0;
        for (int i = 1; i <= 300 && seen == 0; i++) begin
            state = (pause_len > 0 && i >= pause_at && i < pause_at + pause_len) ? 3'd4 : 3'd3;
            @(posedge cp); #1;
            if (i == 10) begin
                ntotal++;
                if (data[TIME_W-1:0] !== TIME_W'(tot - (i - 1) / TICK_DIV))
                    $display("FAIL run_midway remaining=%0d required %0d", data[TIME_W-1:0],
                             tot - (i - 1) / TICK_DIV);
                else npass++;
            end
            if (pause_len > 0 && i == pause_at) frozen = int'(data[TIME_W-1:0]);
            if (pause_len > 0 && i == pause_at + pause_len - 1) begin
                ntotal++;
                if (data[TIME_W-1:0] !== TIME_W'(frozen))
                    $display("FAIL pause_frozen remaining=%0d required %0d", data[TIME_W-1:0], frozen);
                else npass++;
            end
            if (done === 1'b1) seen = i;
        end
        ntotal++;
        if (seen != tot * TICK_DIV + 1 + pause_len || data[TIME_W-1:0] !== '0)
            $display("FAIL done_timing edge=%0d remaining=%0d required edge %0d remaining 0",
                     seen, data[TIME_W-1:0], tot * TICK_DIV + 1 + pause_len);
        else npass++;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge cp); #1;
            if (done === 1'b1) seen++;
        end
        ntotal++;
        if (seen != 0 || data[TIME_W-1:0] !== '0)
            $display("FAIL done_single extra_pulses=%0d remaining=%0d required 0/0", seen, data[TIME_W-1:0]);
        else npass++;
    endtask

    task automatic test_countdown();
        int tot, dcnt = 0;
        drive_cycle(1'b0, 1'b0, 3'd0);
        drive_cycle(1'b0, 1'b0, 3'd2);
        repeat (2) begin drive_cycle(1'b1, 1'b0, 3'd2); drive_cycle(1'b0, 1'b0, 3'd2); end
        repeat (4) begin drive_cycle(1'b1, 1'b1, 3'd2); drive_cycle(1'b0, 1'b1, 3'd2); end
        tot = mtotal(mp, mw);
        ntotal++;
        if (data !== {3'd1, 3'b110, 20'd16})
            $display("FAIL run_setup data=%h required %h", data, {3'd1, 3'b110, 20'd16});
        else npass++;
        run_countdown(0, 0, tot);
        drive_cycle(1'b0, 1'b0, 3'd2);
        drive_cycle(1'b0, 1'b0, 3'd2);
        ntotal++;
        if (data !== exp_d) $display("FAIL abort_reload data=%h required %h", data, exp_d);
        else npass++;
        run_countdown(21, 10, tot);
        drive_cycle(1'b0, 1'b0, 3'd1);
        for (int i = 1; i <= 30; i++) begin
            state = 3'd3;
            @(posedge cp); #1;
            if (done === 1'b1) dcnt++;
        end
        rst = 1'b1; state = 3'd0;
        @(posedge cp); #1;
        ntotal++;
        if (data !== '0 || done !== 1'b0 || setData !== '0)
            $display("FAIL rst_midrun data=%h done=%b setData=%0d required 0/0/0", data, done, setData);
        else npass++;
        rst = 1'b0; mp = 0; mw = DEF_WATER; mheld = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge cp); #1;
            if (done === 1'b1 || data !== '0) dcnt++;
        end
        ntotal++;
        if (dcnt != 0) $display("FAIL rst_nodone events=%0d required 0", dcnt);
        else npass++;
    endtask

    initial begin
        test_reset();
        test_prog_edit();
        test_water_edit();
        test_ignored();
        test_repeat();
        test_random();
        test_countdown();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
